wb_retire_queue: RTL and testbench
==================================

# wb_retire_queue

Parametrised writeback/retire stage for the LoongArch pipeline. Sits between MEM stage and the register file/CSR unit. Buffers up to DEPTH completed instructions in program order and retires one per cycle into registered regfile-write, debug-trace and flush outputs. Adds what the single-entry writeback stage lacks: multi-entry buffering, a retire-stall input, youngest-wins forwarding lookup over all pending writes, and priority exception/ertn flush that discards younger buffered entries.

## Interface
- DEPTH, 4: buffer entries; power of two, ≥2.
- EXCP_W, 15: exception-cause vector width; bit i has priority over bit i+1.
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset; asynchronous, active-low.
- ms_to_ws_valid  in  1  MEM stage offers an instruction.
- ws_allowin  out  1  = (count < DEPTH); handshake completes when ms_to_ws_valid && ws_allowin at a rising edge.
- in_pc / in_result  in  32 each  instruction PC / result.
- in_dest  in  5  destination GR; in_gr_we  in  1  GR write request.
- in_excp  in  EXCP_W  exception causes; in_ertn  in  1  instruction is ertn.
- commit_en  in  1  retire permitted this cycle (low = CSR unit busy).
- rf_we  out  1; rf_waddr  out  5; rf_wdata  out  32  registered GR write port.
- excp_flush / ertn_flush  out  1 each  one-cycle flush pulses.
- flush_ecode  out  6  ecode of the flushing instruction; flush_pc  out  32  its PC.
- debug_wb_pc  out  32; debug_wb_rf_we  out  4; debug_wb_rf_wnum  out  5; debug_wb_rf_wdata  out  32.
- fwd_raddr1 / fwd_raddr2  in  5  forwarding lookups; fwd_hit1 / fwd_hit2  out  1; fwd_data1 / fwd_data2  out  32.

## Operation
- Circular buffer: head/tail pointers log2(DEPTH) bits, wrap modulo DEPTH; count 0..DEPTH.
- Push: accepted entry written at tail. Pop: head retires when count>0 && commit_en. Push and pop in same cycle: count unchanged.
- Normal retire (head in_excp==0, !ertn): next cycle rf_we = gr_we, rf_waddr = dest, rf_wdata = result, debug_wb_pc = pc.
- Exception retire (any in_excp bit): rf_we=0, excp_flush=1, flush_pc=pc, flush_ecode from lowest set bit: 0 INT 0x00, 1 ADEF 0x08, 2 TLBR 0x3F, 3 PIF 0x03, 4 PPI 0x07, 5 SYS 0x0B, 6 BRK 0x0C, 7 INE 0x0D, 8 IPE 0x0E, 9 ALE 0x09, 10 TLBR 0x3F, 11 PME 0x04, 12 PPI 0x07, 13 PIS 0x02, 14 PIL 0x01; bits ≥15 → 0x00.
- Ertn retire (no excp, ertn=1): rf_we=0, ertn_flush=1, flush_pc=pc, flush_ecode=0. Exception beats ertn on same entry.
- Flush retire: at that edge count←0, head←tail; an entry pushed at the same edge is dropped.
- debug_wb_rf_we = {4{rf_we}}; debug_wb_rf_wnum = rf_waddr; debug_wb_rf_wdata = rf_wdata; debug_wb_pc updates on every retire (incl. flush), else holds.
- Forwarding (combinational): candidates = retire output register (rf_we) plus buffered entries with gr_we && in_excp==0; match dest==raddr, raddr≠0; youngest (nearest tail) wins, output register oldest. No hit: hit=0, data=0.

## Timing
- Reset (resetn low, async): count, pointers, rf_we, excp_flush, ertn_flush, flush_ecode, flush_pc, rf_waddr, rf_wdata, all debug outputs = 0; ws_allowin=1 while held.
- Latency: accepted at edge N into empty buffer → retired at edge N+1 (if commit_en) → rf_we high during cycle after N+1. Throughput 1/cycle.
- rf_we, excp_flush, ertn_flush are single-cycle pulses; low in any cycle with no retire.
- ws_allowin depends only on count; full buffer does not accept even if popping that cycle.
- commit_en low with count>0: no retire, outputs pulse low, buffer holds; pushes continue until full.
- Reset mid-operation: all entries discarded immediately; no pulse after resetn rises until a new entry retires.

## Test plan
- Single push pc=0x1C000000, result=0x12345678, dest=5, gr_we=1 → 2 cycles later rf_we=1, rf_waddr=5, rf_wdata=0x12345678, debug_wb_rf_we=4'hF for one cycle.
- commit_en=0, push 4 entries (DEPTH=4) → ws_allowin=0 after 4th; 5th offer not accepted; commit_en=1 → 4 retires in order on consecutive cycles, ws_allowin=1 after first pop.
- Buffer holding A(ok), B(in_excp bit5), C(ok), push D at B's retire edge → A writes, then excp_flush=1, flush_ecode=0x0B, flush_pc=B.pc, rf_we=0; C and D never retire; count=0.
- Entry with in_excp bits 7 and 9 and in_ertn=1 → excp_flush=1, ertn_flush=0, flush_ecode=0x0D.
- Buffered writes dest=3 data 0x11 (older) and 0x22 (younger), fwd_raddr1=3, fwd_raddr2=0 → fwd_hit1=1, fwd_data1=0x22; fwd_hit2=0, fwd_data2=0.
- resetn low for one cycle with 3 entries pending → all outputs 0 at once, ws_allowin=1, no rf_we pulses afterwards.

Source files
------------

// File: rtl/wb_retire_queue_if.sv
// MEM -> WB handshake bundle for the retire queue.
interface wb_retire_queue_if #(
  parameter int unsigned EXCP_W = 15
);
  logic              ms_to_ws_valid;
  logic              ws_allowin;
  logic [31:0]       in_pc;
  logic [31:0]       in_result;
  logic [4:0]        in_dest;
  logic              in_gr_we;
  logic [EXCP_W-1:0] in_excp;
  logic              in_ertn;

  // MEM stage side
  modport master (
    output ms_to_ws_valid, in_pc, in_result, in_dest, in_gr_we, in_excp, in_ertn,
    input  ws_allowin
  );

  // Writeback/retire side
  modport slave (
    input  ms_to_ws_valid, in_pc, in_result, in_dest, in_gr_we, in_excp, in_ertn,
    output ws_allowin
  );
endinterface

// File: rtl/wb_retire_queue.sv
// Writeback/retire queue: buffers completed instructions in program order,
// retires one per cycle into registered regfile/debug/flush outputs, and
// offers youngest-wins forwarding over all pending GR writes.
module wb_retire_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned EXCP_W = 15
) (
  input  logic             clk,
  input  logic             resetn,
  wb_retire_queue_if.slave ms,
  input  logic             commit_en,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             excp_flush,
  output logic             ertn_flush,
  output logic [5:0]       flush_ecode,
  output logic [31:0]      flush_pc,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_we,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata,
  input  logic [4:0]       fwd_raddr1,
  input  logic [4:0]       fwd_raddr2,
  output logic             fwd_hit1,
  output logic             fwd_hit2,
  output logic [31:0]      fwd_data1,
  output logic [31:0]      fwd_data2
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]       pc_q   [DEPTH];
  logic [31:0]       res_q  [DEPTH];
  logic [4:0]        dest_q [DEPTH];
  logic              we_q   [DEPTH];
  logic [EXCP_W-1:0] excp_q [DEPTH];
  logic              ertn_q [DEPTH];

  logic [PTR_W-1:0] head, tail, idx;
  logic [CNT_W-1:0] count;
  logic             allowin, push, pop;
  logic             head_excp, head_flush, ecode_found;
  logic [5:0]       head_ecode;

  function automatic logic [5:0] cause_ecode(input int unsigned bit_idx);
    case (bit_idx)
      0:       return 6'h00;
      1:       return 6'h08;
      2:       return 6'h3F;
      3:       return 6'h03;
      4:       return 6'h07;
      5:       return 6'h0B;
      6:       return 6'h0C;
      7:       return 6'h0D;
      8:       return 6'h0E;
      9:       return 6'h09;
      10:      return 6'h3F;
      11:      return 6'h04;
      12:      return 6'h07;
      13:      return 6'h02;
      14:      return 6'h01;
      default: return 6'h00;
    endcase
  endfunction

  assign allowin       = count < CNT_W'(DEPTH);
  assign ms.ws_allowin = allowin;
  assign push          = ms.ms_to_ws_valid && allowin;
  assign pop           = (count != '0) && commit_en;
  assign head_excp     = |excp_q[head];
  assign head_flush    = pop && (head_excp || ertn_q[head]);

  // Lowest set cause bit of the head entry selects the ecode.
  always_comb begin
    head_ecode  = '0;
    ecode_found = 1'b0;
    for (int unsigned i = 0; i < EXCP_W; i++) begin
      if (excp_q[head][i] && !ecode_found) begin
        head_ecode  = cause_ecode(i);
        ecode_found = 1'b1;
      end
    end
  end

  // Entry storage; a push coinciding with a flush retire is dropped.
  always_ff @(posedge clk) begin
    if (push && !head_flush) begin
      pc_q[tail]   <= ms.in_pc;
      res_q[tail]  <= ms.in_result;
      dest_q[tail] <= ms.in_dest;
      we_q[tail]   <= ms.in_gr_we;
      excp_q[tail] <= ms.in_excp;
      ertn_q[tail] <= ms.in_ertn;
    end
  end

  // Pointer and occupancy bookkeeping; a flush empties the queue by head<=tail.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (head_flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Retire output registers: single-cycle pulses, data/pc hold between retires.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      excp_flush  <= 1'b0;
      ertn_flush  <= 1'b0;
      flush_ecode <= '0;
      flush_pc    <= '0;
      debug_wb_pc <= '0;
    end else begin
      rf_we      <= 1'b0;
      excp_flush <= 1'b0;
      ertn_flush <= 1'b0;
      if (pop) begin
        debug_wb_pc <= pc_q[head];
        if (head_excp) begin
          excp_flush  <= 1'b1;
          flush_pc    <= pc_q[head];
          flush_ecode <= head_ecode;
        end else if (ertn_q[head]) begin
          ertn_flush  <= 1'b1;
          flush_pc    <= pc_q[head];
          flush_ecode <= '0;
        end else begin
          rf_we    <= we_q[head];
          rf_waddr <= dest_q[head];
          rf_wdata <= res_q[head];
        end
      end
    end
  end

  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  // Forwarding: output register is oldest, then buffer head..tail; later match overrides.
  always_comb begin
    fwd_hit1  = rf_we && (rf_waddr == fwd_raddr1) && (fwd_raddr1 != '0);
    fwd_data1 = fwd_hit1 ? rf_wdata : '0;
    fwd_hit2  = rf_we && (rf_waddr == fwd_raddr2) && (fwd_raddr2 != '0);
    fwd_data2 = fwd_hit2 ? rf_wdata : '0;
    idx       = head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (i < 32'(count) && we_q[idx] && (excp_q[idx] == '0)) begin
        if ((dest_q[idx] == fwd_raddr1) && (fwd_raddr1 != '0)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = res_q[idx];
        end
        if ((dest_q[idx] == fwd_raddr2) && (fwd_raddr2 != '0)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = res_q[idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_retire_queue.sv
// Scoreboard bench for wb_retire_queue: a queue model predicts each retire,
// expectations are pushed at the retire edge and compared half a cycle later.
module tb_wb_retire_queue;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned EXCP_W = 15;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        commit_en;
  logic        rf_we, excp_flush, ertn_flush, fwd_hit1, fwd_hit2;
  logic [4:0]  rf_waddr, debug_wb_rf_wnum, fwd_raddr1, fwd_raddr2;
  logic [31:0] rf_wdata, flush_pc, debug_wb_pc, debug_wb_rf_wdata, fwd_data1, fwd_data2;
  logic [5:0]  flush_ecode;
  logic [3:0]  debug_wb_rf_we;

  always #5 clk = ~clk;

  wb_retire_queue_if #(.EXCP_W(EXCP_W)) ms_if ();

  wb_retire_queue #(.DEPTH(DEPTH), .EXCP_W(EXCP_W)) dut (
    .clk(clk), .resetn(resetn), .ms(ms_if), .commit_en(commit_en),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush),
    .flush_ecode(flush_ecode), .flush_pc(flush_pc),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .fwd_raddr1(fwd_raddr1), .fwd_raddr2(fwd_raddr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  typedef struct {
    logic [31:0]       pc;
    logic [31:0]       result;
    logic [4:0]        dest;
    logic              gr_we;
    logic [EXCP_W-1:0] excp;
    logic              ertn;
  } ent_t;

  typedef struct {
    logic        rf_we;
    logic        excp_f;
    logic        ertn_f;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [5:0]  ecode;
  } exp_t;

  ent_t        mq[$];
  exp_t        eq[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] model_ecode(input logic [EXCP_W-1:0] ex);
    logic [5:0] tab [15] = '{6'h00, 6'h08, 6'h3F, 6'h03, 6'h07, 6'h0B, 6'h0C, 6'h0D,
                             6'h0E, 6'h09, 6'h3F, 6'h04, 6'h07, 6'h02, 6'h01};
    for (int i = 0; i < int'(EXCP_W); i++) if (ex[i]) return tab[i];
    return 6'h00;
  endfunction

  function automatic logic [32:0] model_fwd(input logic [4:0] ra);
    logic [32:0] r = '0;
    if (ra != 5'd0) begin
      if (m_we && m_waddr == ra) r = {1'b1, m_wdata};
      foreach (mq[i])
        if (mq[i].gr_we && mq[i].excp == '0 && mq[i].dest == ra) r = {1'b1, mq[i].result};
    end
    return r;
  endfunction

  task automatic offer(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest,
                       input logic we, input logic [EXCP_W-1:0] ex, input logic ertn);
    ms_if.ms_to_ws_valid = 1'b1;
    ms_if.in_pc = pc;  ms_if.in_result = res;  ms_if.in_dest = dest;
    ms_if.in_gr_we = we;  ms_if.in_excp = ex;  ms_if.in_ertn = ertn;
  endtask

  task automatic idle();
    ms_if.ms_to_ws_valid = 1'b0;
  endtask

  // One clock: predict, let the edge happen, update model, compare at negedge.
  task automatic cycle();
    logic acc, ret, fl;
    ent_t cur, e;
    exp_t x;
    logic [32:0] f;
    acc = ms_if.ms_to_ws_valid && (mq.size() < DEPTH);
    ret = commit_en && (mq.size() > 0);
    cur.pc = ms_if.in_pc;  cur.result = ms_if.in_result;  cur.dest = ms_if.in_dest;
    cur.gr_we = ms_if.in_gr_we;  cur.excp = ms_if.in_excp;  cur.ertn = ms_if.in_ertn;
    fl = 1'b0;
    @(posedge clk);
    m_we = 1'b0;
    if (ret) begin
      e = mq.pop_front();
      x.excp_f = (e.excp != '0);
      x.ertn_f = (e.excp == '0) && e.ertn;
      fl = x.excp_f || x.ertn_f;
      x.rf_we = !fl && e.gr_we;
      x.waddr = e.dest;
      x.wdata = e.result;
      x.pc    = e.pc;
      x.ecode = x.excp_f ? model_ecode(e.excp) : 6'h00;
      eq.push_back(x);
      if (fl) mq.delete();
      else begin
        m_we = e.gr_we;  m_waddr = e.dest;  m_wdata = e.result;
      end
    end
    if (acc && !fl) mq.push_back(cur);
    @(negedge clk);
    check("allowin", ms_if.ws_allowin, mq.size() < DEPTH);
    if (eq.size() > 0) begin
      x = eq.pop_front();
      check("rf_we", rf_we, x.rf_we);
      check("excp_flush", excp_flush, x.excp_f);
      check("ertn_flush", ertn_flush, x.ertn_f);
      check("debug_wb_pc", debug_wb_pc, x.pc);
      if (x.excp_f || x.ertn_f) begin
        check("flush_pc", flush_pc, x.pc);
        check("flush_ecode", flush_ecode, x.ecode);
      end else begin
        check("rf_waddr", rf_waddr, x.waddr);
        check("rf_wdata", rf_wdata, x.wdata);
        check("dbg_rf_we", debug_wb_rf_we, {4{x.rf_we}});
        check("dbg_wnum", debug_wb_rf_wnum, x.waddr);
        check("dbg_wdata", debug_wb_rf_wdata, x.wdata);
      end
    end else begin
      check("idle_rf_we", rf_we, 1'b0);
      check("idle_excp_flush", excp_flush, 1'b0);
      check("idle_ertn_flush", ertn_flush, 1'b0);
    end
    f = model_fwd(fwd_raddr1);
    check("fwd1", {fwd_hit1, fwd_data1}, f);
    f = model_fwd(fwd_raddr2);
    check("fwd2", {fwd_hit2, fwd_data2}, f);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rf_we"}, rf_we, 1'b0);
    check({tag, "_rf_waddr"}, rf_waddr, 5'd0);
    check({tag, "_rf_wdata"}, rf_wdata, 32'd0);
    check({tag, "_excp_flush"}, excp_flush, 1'b0);
    check({tag, "_ertn_flush"}, ertn_flush, 1'b0);
    check({tag, "_flush_ecode"}, flush_ecode, 6'd0);
    check({tag, "_flush_pc"}, flush_pc, 32'd0);
    check({tag, "_dbg_pc"}, debug_wb_pc, 32'd0);
    check({tag, "_dbg_we"}, debug_wb_rf_we, 4'd0);
    check({tag, "_dbg_wnum"}, debug_wb_rf_wnum, 5'd0);
    check({tag, "_dbg_wdata"}, debug_wb_rf_wdata, 32'd0);
    check({tag, "_allowin"}, ms_if.ws_allowin, 1'b1);
  endtask

  initial begin
    commit_en = 1'b0;
    fwd_raddr1 = '0;
    fwd_raddr2 = '0;
    ms_if.ms_to_ws_valid = 1'b0;
    ms_if.in_pc = '0;  ms_if.in_result = '0;  ms_if.in_dest = '0;
    ms_if.in_gr_we = 1'b0;  ms_if.in_excp = '0;  ms_if.in_ertn = 1'b0;

    // Power-on reset
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    resetn = 1'b1;
    commit_en = 1'b1;

    // Single push, retire two edges later
    offer(32'h1C00_0000, 32'h1234_5678, 5'd5, 1'b1, '0, 1'b0);
    cycle();
    idle();
    repeat (3) cycle();

    // Fill with commit stalled, offer a fifth, then drain in order
    commit_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(32'h1C00_0100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 5'(i + 1), 1'b1, '0, 1'b0);
      cycle();
    end
    offer(32'h1C00_0200, 32'hDEAD_BEEF, 5'd9, 1'b1, '0, 1'b0);
    cycle();
    idle();
    commit_en = 1'b1;
    repeat (5) cycle();

    // A ok, B exception (SYS), C ok; D pushed on B's retire edge is dropped
    commit_en = 1'b0;
    offer(32'h1C00_0300, 32'h0000_00AA, 5'd7, 1'b1, '0, 1'b0);
    cycle();
    offer(32'h1C00_0304, 32'h0000_00BB, 5'd8, 1'b1, 15'(1 << 5), 1'b0);
    cycle();
    offer(32'h1C00_0308, 32'h0000_00CC, 5'd9, 1'b1, '0, 1'b0);
    cycle();
    idle();
    commit_en = 1'b1;
    cycle();
    offer(32'h1C00_030C, 32'h0000_00DD, 5'd10, 1'b1, '0, 1'b0);
    cycle();
    idle();
    repeat (3) cycle();

    // Exception beats ertn; lowest cause bit (INE) wins over ALE
    offer(32'h1C00_0400, 32'h0, 5'd4, 1'b1, 15'((1 << 7) | (1 << 9)), 1'b1);
    cycle();
    idle();
    repeat (2) cycle();

    // Plain ertn
    offer(32'h1C00_0500, 32'h0, 5'd0, 1'b0, '0, 1'b1);
    cycle();
    idle();
    repeat (2) cycle();

    // Forwarding: younger buffered write wins, raddr 0 never hits
    commit_en = 1'b0;
    fwd_raddr1 = 5'd3;
    fwd_raddr2 = 5'd0;
    offer(32'h1C00_0600, 32'h0000_0011, 5'd3, 1'b1, '0, 1'b0);
    cycle();
    offer(32'h1C00_0604, 32'h0000_0022, 5'd3, 1'b1, '0, 1'b0);
    cycle();
    idle();
    cycle();
    commit_en = 1'b1;
    repeat (4) cycle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 6)
        offer($urandom, $urandom, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 11) == 0) ? 15'(1 << $urandom_range(0, 14)) : '0,
              ($urandom_range(0, 15) == 0));
      else
        idle();
      commit_en  = ($urandom_range(0, 9) < 7);
      fwd_raddr1 = 5'($urandom_range(0, 7));
      fwd_raddr2 = 5'($urandom_range(0, 7));
      cycle();
    end
    idle();
    commit_en = 1'b1;
    repeat (DEPTH + 2) cycle();

    // Reset with three entries pending
    commit_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(32'h1C00_0700 + 32'(i * 4), 32'h5500_0000 + 32'(i), 5'(i + 11), 1'b1, '0, 1'b0);
      cycle();
    end
    idle();
    resetn = 1'b0;
    #1;
    mq.delete();
    eq.delete();
    m_we = 1'b0;
    check_reset_outputs("midrst");
    @(negedge clk);
    resetn = 1'b1;
    commit_en = 1'b1;
    repeat (5) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
